// File: rtl/rsa_xcel_naive_xcel_job_seq_pkg.sv
// Shared types and constants for the RSA xcel job sequencer.
// Holds the FSM state enum, request step numbers, xcel register numbers and
// the xcel request/response message structs.
package rsa_xcel_naive_xcel_job_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Request steps, issued in this order for every job
    localparam logic [2:0] STEP_BASE = 3'd0;
    localparam logic [2:0] STEP_EXP  = 3'd1;
    localparam logic [2:0] STEP_MOD  = 3'd2;
    localparam logic [2:0] STEP_GO   = 3'd3;
    localparam logic [2:0] STEP_READ = 3'd4;

    // Xcel register numbers
    localparam logic [4:0] XR_GO   = 5'd0;
    localparam logic [4:0] XR_BASE = 5'd1;
    localparam logic [4:0] XR_EXP  = 5'd2;
    localparam logic [4:0] XR_MOD  = 5'd3;

    localparam logic XCEL_TYPE_READ  = 1'b0;
    localparam logic XCEL_TYPE_WRITE = 1'b1;

    typedef struct packed {
        logic [7:0]  opaque;
        logic        type_;
        logic [4:0]  addr;
        logic [31:0] data;
    } xcel_req_t;

    typedef struct packed {
        logic [7:0]  opaque;
        logic        type_;
        logic [31:0] data;
    } xcel_resp_t;

endpackage

// File: rtl/rsa_xcel_naive_xcel_job_seq_ctrl.sv
// Control for the job sequencer: IDLE/SEND/WAIT/DONE FSM plus the 0..4
// step counter that selects which xcel request is being issued.
module rsa_xcel_naive_xcel_job_seq_ctrl
    import rsa_xcel_naive_xcel_job_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_job_val,
    input  logic       i_req_rdy,
    input  logic       i_resp_val,
    input  logic       i_result_rdy,
    output logic       o_job_rdy,
    output logic       o_req_val,
    output logic       o_resp_rdy,
    output logic       o_result_val,
    output logic       o_job_go,
    output logic       o_result_load,
    output logic       o_busy,
    output logic [2:0] o_step
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_step;

    // State and step registers; step restarts on job accept and advances per response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_step  <= STEP_BASE;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && i_job_val)
                r_step <= STEP_BASE;
            else if (r_state == ST_WAIT && i_resp_val && r_step != STEP_READ)
                r_step <= r_step + 3'd1;
        end
    end

    // Next-state logic: one request outstanding at a time
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (i_job_val)    w_state_nxt = ST_SEND;
            ST_SEND: if (i_req_rdy)    w_state_nxt = ST_WAIT;
            ST_WAIT: if (i_resp_val)   w_state_nxt = (r_step == STEP_READ) ? ST_DONE : ST_SEND;
            ST_DONE: if (i_result_rdy) w_state_nxt = ST_IDLE;
            default:                   w_state_nxt = ST_IDLE;
        endcase
    end

    // Stream handshake outputs depend on state only
    always_comb begin
        o_job_rdy     = (r_state == ST_IDLE);
        o_req_val     = (r_state == ST_SEND);
        o_resp_rdy    = (r_state == ST_WAIT);
        o_result_val  = (r_state == ST_DONE);
        o_job_go      = (r_state == ST_IDLE) && i_job_val;
        o_result_load = (r_state == ST_WAIT) && i_resp_val && (r_step == STEP_READ);
        o_busy        = (r_state == ST_SEND) || (r_state == ST_WAIT);
        o_step        = r_step;
    end

endmodule

// File: rtl/rsa_xcel_naive_xcel_job_seq.sv
// RSA xcel job sequencer: accepts one {base,exp,mod} job, replays the xcel
// register protocol (xr1, xr2, xr3, go, read xr0) and returns the result.
// Optional: RSA_XCEL_JOB_SEQ_PERF_EN adds a job_cycles output counting the
// SEND/WAIT cycles of the most recent job.
module rsa_xcel_naive_xcel_job_seq
    import rsa_xcel_naive_xcel_job_seq_pkg::*;
#(
    parameter logic [7:0] p_opaque = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [95:0] job_istream_msg,
    input  logic        job_istream_val,
    output logic        job_istream_rdy,
    output xcel_req_t   xcel_reqstream_msg,
    output logic        xcel_reqstream_val,
    input  logic        xcel_reqstream_rdy,
    input  xcel_resp_t  xcel_respstream_msg,
    input  logic        xcel_respstream_val,
    output logic        xcel_respstream_rdy,
    output logic [31:0] result_ostream_msg,
    output logic        result_ostream_val,
    input  logic        result_ostream_rdy
`ifdef RSA_XCEL_JOB_SEQ_PERF_EN
    ,
    output logic [31:0] job_cycles
`endif
);

    logic [95:0] r_job;
    logic [31:0] r_result;
    logic        w_job_go;
    logic        w_result_load;
    logic        w_busy;
    logic [2:0]  w_step;
    xcel_req_t   w_req;

    rsa_xcel_naive_xcel_job_seq_ctrl u_ctrl (
        .clk           (clk),
        .reset         (reset),
        .i_job_val     (job_istream_val),
        .i_req_rdy     (xcel_reqstream_rdy),
        .i_resp_val    (xcel_respstream_val),
        .i_result_rdy  (result_ostream_rdy),
        .o_job_rdy     (job_istream_rdy),
        .o_req_val     (xcel_reqstream_val),
        .o_resp_rdy    (xcel_respstream_rdy),
        .o_result_val  (result_ostream_val),
        .o_job_go      (w_job_go),
        .o_result_load (w_result_load),
        .o_busy        (w_busy),
        .o_step        (w_step)
    );

    // Job and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_job    <= '0;
            r_result <= '0;
        end else begin
            if (w_job_go)      r_job    <= job_istream_msg;
            if (w_result_load) r_result <= xcel_respstream_msg.data;
        end
    end

    // Request mux: fields come only from registers, so msg is stable under stall
    always_comb begin
        w_req        = '0;
        w_req.opaque = p_opaque;
        w_req.type_  = XCEL_TYPE_WRITE;
        case (w_step)
            STEP_BASE: begin w_req.addr = XR_BASE; w_req.data = r_job[95:64]; end
            STEP_EXP:  begin w_req.addr = XR_EXP;  w_req.data = r_job[63:32]; end
            STEP_MOD:  begin w_req.addr = XR_MOD;  w_req.data = r_job[31:0];  end
            STEP_GO:   begin w_req.addr = XR_GO;   w_req.data = 32'd0;        end
            default:   begin
                w_req.type_ = XCEL_TYPE_READ;
                w_req.addr  = XR_GO;
                w_req.data  = 32'd0;
            end
        endcase
    end

    assign xcel_reqstream_msg = w_req;
    assign result_ostream_msg = r_result;

    // Only the data of the final read response is meaningful
    logic w_unused_resp;
    assign w_unused_resp = ^{xcel_respstream_msg.opaque, xcel_respstream_msg.type_};

`ifdef RSA_XCEL_JOB_SEQ_PERF_EN
    logic [31:0] r_cycles;

    // Cycle counter: cleared at job accept, counts SEND/WAIT, frozen otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         r_cycles <= '0;
        else if (w_job_go) r_cycles <= '0;
        else if (w_busy)   r_cycles <= r_cycles + 32'd1;
    end

    assign job_cycles = r_cycles;
`else
    logic w_unused_busy;
    assign w_unused_busy = w_busy;
`endif

endmodule

// File: tb/tb_rsa_xcel_naive_xcel_job_seq.sv
// Scoreboard bench for the RSA xcel job sequencer with a behavioural xcel model.
module tb_rsa_xcel_naive_xcel_job_seq;
    import rsa_xcel_naive_xcel_job_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [95:0] job_msg;
    logic        job_val, job_rdy;
    xcel_req_t   req_msg;
    logic        req_val, req_rdy;
    xcel_resp_t  resp_msg;
    logic        resp_val, resp_rdy;
    logic [31:0] res_msg;
    logic        res_val, res_rdy;
`ifdef RSA_XCEL_JOB_SEQ_PERF_EN
    logic [31:0] job_cycles;
`endif

    rsa_xcel_naive_xcel_job_seq dut (
        .clk                 (clk),
        .reset               (reset),
        .job_istream_msg     (job_msg),
        .job_istream_val     (job_val),
        .job_istream_rdy     (job_rdy),
        .xcel_reqstream_msg  (req_msg),
        .xcel_reqstream_val  (req_val),
        .xcel_reqstream_rdy  (req_rdy),
        .xcel_respstream_msg (resp_msg),
        .xcel_respstream_val (resp_val),
        .xcel_respstream_rdy (resp_rdy),
        .result_ostream_msg  (res_msg),
        .result_ostream_val  (res_val),
        .result_ostream_rdy  (res_rdy)
`ifdef RSA_XCEL_JOB_SEQ_PERF_EN
        ,
        .job_cycles          (job_cycles)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    xcel_req_t   exp_req[$];
    logic [31:0] exp_res[$];
    int          delay_cfg[5];
    bit          stall_req = 0, stall_res = 0, spur = 0;
    bit          pending = 0;
    int          dly_cnt = 0;
    int          req_idx = 0;
    logic [31:0] xr[4];
    logic [31:0] xres = 0;
    xcel_req_t   last_req;
    bit          prev_req_stall = 0, prev_res_stall = 0;
    xcel_req_t   prev_req;
    logic [31:0] prev_res;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] modexp(input logic [31:0] b, input logic [31:0] e,
                                           input logic [31:0] m);
        logic [63:0] r, x, mm;
        if (m == 32'd0) return 32'd0;
        mm = {32'd0, m};
        r  = 64'd1 % mm;
        x  = {32'd0, b} % mm;
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return r[31:0];
    endfunction

    // Xcel model, stream sinks and scoreboard monitor, all working at negedge
    always @(negedge clk) begin
        if (reset) begin
            pending = 0; dly_cnt = 0; req_idx = 0;
            resp_val = 1'b0; req_rdy = 1'b1; res_rdy = 1'b1;
            prev_req_stall = 0; prev_res_stall = 0;
        end else begin
            req_rdy = stall_req ? 1'($urandom_range(0, 1)) : 1'b1;
            res_rdy = stall_res ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pending && dly_cnt == 0) begin
                resp_val      = 1'b1;
                resp_msg.opaque = last_req.opaque;
                resp_msg.type_  = last_req.type_;
                resp_msg.data   = (last_req.type_ == XCEL_TYPE_READ) ? xres : 32'd0;
            end else begin
                resp_val = spur;
                if (spur) resp_msg = '{opaque: 8'hEE, type_: 1'b1, data: 32'hDEAD};
                if (pending) dly_cnt--;
            end
            #1;
            if (!reset) begin
                if (spur && resp_val) chk("spurious_resp_rdy", 64'(resp_rdy), 64'd0);
                if (pending && !resp_val) chk("one_outstanding", 64'(req_val), 64'd0);
                if (pending && resp_val && resp_rdy) pending = 0;
                if (prev_req_stall) chk("req_msg_stable", 64'(req_msg), 64'(prev_req));
                if (req_val && req_rdy) begin
                    if (exp_req.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_req: got %0h expected none", req_msg);
                    end else begin
                        chk("req_msg", 64'(req_msg), 64'(exp_req.pop_front()));
                    end
                    last_req = req_msg;
                    if (req_msg.type_ == XCEL_TYPE_WRITE) begin
                        if (req_msg.addr == XR_GO) xres = modexp(xr[1], xr[2], xr[3]);
                        else xr[req_msg.addr[1:0]] = req_msg.data;
                    end
                    pending = 1;
                    dly_cnt = delay_cfg[req_idx];
                    req_idx = (req_idx + 1) % 5;
                end
                prev_req_stall = req_val && !req_rdy;
                prev_req       = req_msg;
                if (res_val) chk("job_rdy_low_while_result", 64'(job_rdy), 64'd0);
                if (prev_res_stall) chk("result_held", 64'(res_msg), 64'(prev_res));
                if (res_val && res_rdy) begin
                    if (exp_res.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_result: got %0d expected none", res_msg);
                    end else begin
                        chk("result", 64'(res_msg), 64'(exp_res.pop_front()));
                    end
                end
                prev_res_stall = res_val && !res_rdy;
                prev_res       = res_msg;
            end
        end
    end

    task automatic send_job(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m,
                            input logic [31:0] r);
        int n = 0;
        exp_req.push_back('{opaque: 8'h00, type_: XCEL_TYPE_WRITE, addr: XR_BASE, data: b});
        exp_req.push_back('{opaque: 8'h00, type_: XCEL_TYPE_WRITE, addr: XR_EXP,  data: e});
        exp_req.push_back('{opaque: 8'h00, type_: XCEL_TYPE_WRITE, addr: XR_MOD,  data: m});
        exp_req.push_back('{opaque: 8'h00, type_: XCEL_TYPE_WRITE, addr: XR_GO,   data: 32'd0});
        exp_req.push_back('{opaque: 8'h00, type_: XCEL_TYPE_READ,  addr: XR_GO,   data: 32'd0});
        exp_res.push_back(r);
        @(negedge clk);
        job_msg = {b, e, m};
        job_val = 1'b1;
        #2;
        while (!job_rdy && n < 300) begin
            @(negedge clk); #2; n++;
        end
        if (!job_rdy) begin
            checks++; failures++;
            $display("FAIL job_accept_timeout: got rdy=0 expected rdy=1");
        end
        @(posedge clk);
        #1 job_val = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_res.size() != 0 && n < 500) begin
            @(negedge clk); n++;
        end
        if (exp_res.size() != 0) begin
            checks++; failures++;
            $display("FAIL result_timeout: got %0d pending expected 0", exp_res.size());
        end
    endtask

    initial begin
        int n;
        reset = 1'b1; job_val = 1'b0; job_msg = '0;
        resp_val = 1'b0; resp_msg = '0; req_rdy = 1'b1; res_rdy = 1'b1;
        for (int i = 0; i < 5; i++) delay_cfg[i] = 0;
        for (int i = 0; i < 4; i++) xr[i] = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_val", 64'(req_val), 64'd0);
        chk("rst_res_val", 64'(res_val), 64'd0);
        chk("rst_resp_rdy", 64'(resp_rdy), 64'd0);
`ifdef RSA_XCEL_JOB_SEQ_PERF_EN
        chk("rst_job_cycles", 64'(job_cycles), 64'd0);
`endif
        @(posedge clk); #3 reset = 1'b0;
        #1;
        chk("idle_job_rdy", 64'(job_rdy), 64'd1);
        chk("idle_resp_rdy", 64'(resp_rdy), 64'd0);

        // Response arriving while idle must not be consumed
        spur = 1;
        repeat (3) @(posedge clk);
        spur = 0;
        repeat (2) @(posedge clk);

        // Basic job plus latency (and cycle count when enabled)
        send_job(32'd4, 32'd13, 32'd497, 32'd445);
        n = 0;
        while (!res_val && n < 50) begin
            @(posedge clk); n++;
            @(negedge clk); #2;
            if (n == 5) chk("busy_job_rdy", 64'(job_rdy), 64'd0);
        end
        chk("latency", 64'(n), 64'd10);
`ifdef RSA_XCEL_JOB_SEQ_PERF_EN
        chk("job_cycles", 64'(job_cycles), 64'd10);
`endif
        wait_done();

        // Back-to-back jobs, exponent 0 boundary
        send_job(32'd2, 32'd10, 32'd1000, 32'd24);
        send_job(32'd3, 32'd0, 32'd7, 32'd1);
        wait_done();

        // Modulus 0 passed through; model returns 0
        send_job(32'd9, 32'd5, 32'd0, 32'd0);
        wait_done();

        // Random stalls on request and result sinks
        stall_req = 1; stall_res = 1;
        send_job(32'd5, 32'd3, 32'd13, 32'd8);
        wait_done();
        stall_req = 0; stall_res = 0;

        // Long response delay on step 2
        delay_cfg[2] = 20;
        send_job(32'd4, 32'd13, 32'd497, 32'd445);
        wait_done();
        delay_cfg[2] = 0;

        // Reset while waiting on the step-3 response
        delay_cfg[3] = 100;
        send_job(32'd4, 32'd13, 32'd497, 32'd445);
        n = 0;
        while (!(pending && req_idx == 4) && n < 100) begin
            @(negedge clk); #2; n++;
        end
        chk("reached_step3_wait", 64'(pending && req_idx == 4), 64'd1);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("rst_mid_req_val", 64'(req_val), 64'd0);
        chk("rst_mid_res_val", 64'(res_val), 64'd0);
        chk("rst_mid_resp_rdy", 64'(resp_rdy), 64'd0);
        chk("rst_mid_job_rdy", 64'(job_rdy), 64'd1);
        exp_req.delete();
        exp_res.delete();
        delay_cfg[3] = 0;
        for (int i = 0; i < 4; i++) xr[i] = 32'd0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        send_job(32'd7, 32'd2, 32'd10, 32'd9);
        wait_done();
        repeat (3) @(posedge clk);
        chk("final_req_queue_empty", 64'(exp_req.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
